// File: rtl/packet_stream_tx.sv
// Frame transmitter: pops 32-bit words from a show-ahead FIFO and drives an
// Avalon-ST-style stream with sop/eop/empty/error framing and ready backpressure.
module packet_stream_tx #(
    parameter int unsigned MAX_BYTES      = 1518,
    parameter int unsigned UNDERRUN_LIMIT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [10:0] frame_len,
    input  logic        rdempty,
    input  logic [31:0] fifo_data,
    output logic        rdreq,
    input  logic        ready,
    output logic [31:0] data_out,
    output logic        sop,
    output logic        eop,
    output logic        valid,
    output logic [1:0]  empty,
    output logic [5:0]  error,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int unsigned LEN_W    = 11;
    localparam int unsigned WL_W     = 9;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ERR_W    = 6;
    localparam int unsigned STARVE_W = $clog2(UNDERRUN_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ABORT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          tail_q, tail_d;
    logic [WL_W-1:0]     words_left_q, words_left_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                valid_q, valid_d;
    logic [1:0]          empty_q, empty_d;
    logic [ERR_W-1:0]    error_q, error_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    logic load;
    logic accept;
    logic len_ok;

    // A word may be popped only when the output register is free or draining.
    assign load   = (state_q == SEND) && (words_left_q != '0) && !rdempty && (!valid_q || ready);
    assign accept = valid_q && ready;
    assign len_ok = (frame_len != '0) && (32'(frame_len) <= MAX_BYTES);

    always_comb begin
        state_d      = state_q;
        tail_d       = tail_q;
        words_left_d = words_left_q;
        starve_d     = starve_q;
        first_d      = first_q;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        valid_d      = valid_q;
        empty_d      = empty_q;
        error_d      = error_q;
        done_d       = 1'b0;
        ferr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        tail_d       = frame_len[1:0];
                        words_left_d = WL_W'((frame_len + LEN_W'(3)) >> 2);
                        first_d      = 1'b1;
                        starve_d     = '0;
                        state_d      = SEND;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (accept) begin
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    empty_d = 2'd0;
                end
                if (load) begin
                    data_d       = fifo_data;
                    valid_d      = 1'b1;
                    sop_d        = first_q;
                    eop_d        = (words_left_q == WL_W'(1));
                    empty_d      = (words_left_q == WL_W'(1)) ? 2'(3'd4 - {1'b0, tail_q}) : 2'd0;
                    error_d      = '0;
                    first_d      = 1'b0;
                    words_left_d = words_left_q - WL_W'(1);
                    starve_d     = '0;
                end else if (!valid_q && (words_left_q != '0) && rdempty) begin
                    starve_d = starve_q + STARVE_W'(1);
                    // Starved too long: replace the stream with a single error-tagged eop beat.
                    if (32'(starve_q) + 32'd1 >= UNDERRUN_LIMIT) begin
                        state_d = ABORT;
                        data_d  = '0;
                        valid_d = 1'b1;
                        sop_d   = first_q;
                        eop_d   = 1'b1;
                        empty_d = 2'd0;
                        error_d = ERR_W'(1);
                    end
                end
                if (accept && eop_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ABORT: begin
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    error_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            tail_q       <= '0;
            words_left_q <= '0;
            starve_q     <= '0;
            first_q      <= 1'b0;
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            valid_q      <= 1'b0;
            empty_q      <= '0;
            error_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tail_q       <= tail_d;
            words_left_q <= words_left_d;
            starve_q     <= starve_d;
            first_q      <= first_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            valid_q      <= valid_d;
            empty_q      <= empty_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
        end
    end

    assign rdreq     = load;
    assign data_out  = data_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign valid     = valid_q;
    assign empty     = empty_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_packet_stream_tx.sv
// Self-checking bench for packet_stream_tx: queue-based FIFO and sink model,
// expected beat lists built directly from frame length and FIFO contents.
module tb_packet_stream_tx;

    localparam int MAXB = 1518;
    localparam int ULIM = 16;
    localparam int TR   = 1024;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [10:0] frame_len;
    logic        rdempty;
    logic [31:0] fifo_data;
    logic        rdreq;
    logic        ready;
    logic [31:0] data_out;
    logic        sop, eop, valid;
    logic [1:0]  empty;
    logic [5:0]  error;
    logic        busy, done, frame_err;

    packet_stream_tx #(.MAX_BYTES(MAXB), .UNDERRUN_LIMIT(ULIM)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .frame_len(frame_len),
        .rdempty(rdempty), .fifo_data(fifo_data), .rdreq(rdreq), .ready(ready),
        .data_out(data_out), .sop(sop), .eop(eop), .valid(valid), .empty(empty),
        .error(error), .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  emp;
        logic [5:0]  err;
    } beat_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo_q[$];
    beat_t       got_q[$];
    beat_t       exp_q[$];

    int cyc, rdreq_cnt, done_cnt, done_cyc, ferr_cnt, ferr_cyc, busy_cnt, hold_viol, stall_rdreq;
    int ready_mode;
    bit fe_en, pend_start, b2b_arm, prev_stall;
    logic [10:0] b2b_len;
    beat_t prev_b;
    bit tr_valid[TR];
    bit tr_sop[TR];
    bit tr_eop[TR];
    logic [1:0] tr_empty[TR];

    // One clock cycle: drive inputs at negedge, sample outputs 1ns later, model FIFO pop and sink.
    task automatic step();
        beat_t cur;
        start = pend_start;
        pend_start = 1'b0;
        rdempty = (fifo_q.size() == 0) || (fe_en && ($urandom_range(0, 4) == 0));
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        cur = {data_out, sop, eop, empty, error};
        if (prev_stall && (cur !== prev_b)) hold_viol++;
        if (valid && !ready && rdreq) stall_rdreq++;
        if (rdreq) begin
            rdreq_cnt++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (valid && ready) got_q.push_back(cur);
        prev_stall = valid && !ready;
        prev_b = cur;
        if (cyc < TR) begin
            tr_valid[cyc] = valid;
            tr_sop[cyc]   = sop;
            tr_eop[cyc]   = eop;
            tr_empty[cyc] = empty;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (b2b_arm) begin
                start = 1'b1;
                frame_len = b2b_len;
                b2b_arm = 1'b0;
            end
        end
        if (frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (busy) busy_cnt++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        cyc = 0; rdreq_cnt = 0; done_cnt = 0; done_cyc = -1; ferr_cnt = 0; ferr_cyc = -1;
        busy_cnt = 0; hold_viol = 0; stall_rdreq = 0; prev_stall = 1'b0;
        got_q.delete();
        for (int i = 0; i < TR; i++) begin
            tr_valid[i] = 1'b0; tr_sop[i] = 1'b0; tr_eop[i] = 1'b0; tr_empty[i] = 2'd0;
        end
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    endtask

    // Expected beats of one frame whose first word sits at fifo_q[off].
    function automatic void make_exp(input int len, input int off);
        int w;
        logic [1:0] emp;
        w = (len + 3) / 4;
        for (int i = 0; i < w; i++) begin
            emp = (i == w - 1) ? 2'((4 - len % 4) % 4) : 2'd0;
            exp_q.push_back({fifo_q[off + i], (i == 0), (i == w - 1), emp, 6'd0});
        end
    endfunction

    function automatic int beats_bad();
        int n;
        n = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic run_frame(input int len, input int budget);
        clear_logs();
        frame_len = 11'(len);
        pend_start = 1'b1;
        step();
        while (done_cnt == 0 && cyc < budget) step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({data_out, sop, eop, valid, empty, error, busy, done, frame_err, rdreq} !== 47'd0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h sop=%b eop=%b valid=%b empty=%0d error=%0d busy=%b done=%b ferr=%b rdreq=%b required all 0",
                     data_out, sop, eop, valid, empty, error, busy, done, frame_err, rdreq);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, busy, done, frame_err, rdreq} !== 5'd0) begin
            failures++;
            $display("FAIL reset_release got valid=%b busy=%b done=%b ferr=%b rdreq=%b required 0",
                     valid, busy, done, frame_err, rdreq);
        end
    endtask

    task automatic test_frame_64(input string tag);
        int nv;
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete(); exp_q.delete();
        preload(16);
        make_exp(64, 0);
        run_frame(64, 100);
        checks++;
        if (beats_bad() != 0) begin
            failures++;
            $display("FAIL %s_beats got %0d beats (%0d bad) required %0d matching", tag, got_q.size(), beats_bad(), exp_q.size());
        end
        nv = 0;
        for (int i = 0; i < 40; i++) if (tr_valid[i]) nv++;
        checks++;
        if (!(tr_valid[2] && tr_sop[2] && !tr_valid[1] && tr_valid[17] && !tr_valid[18] && nv == 16)) begin
            failures++;
            $display("FAIL %s_valid_window got v1=%b v2=%b sop2=%b v17=%b v18=%b nvalid=%0d required 0,1,1,1,0,16",
                     tag, tr_valid[1], tr_valid[2], tr_sop[2], tr_valid[17], tr_valid[18], nv);
        end
        checks++;
        if (!(tr_eop[17] && tr_empty[17] == 2'd0)) begin
            failures++;
            $display("FAIL %s_eop17 got eop=%b empty=%0d required eop=1 empty=0", tag, tr_eop[17], tr_empty[17]);
        end
        checks++;
        if (done_cyc != 18 || done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done got cycle=%0d count=%0d required cycle=18 count=1", tag, done_cyc, done_cnt);
        end
        checks++;
        if (rdreq_cnt != 16) begin
            failures++;
            $display("FAIL %s_rdreq got %0d required 16", tag, rdreq_cnt);
        end
    endtask

    task automatic test_short_frames();
        int lens[3] = '{61, 1, 1518};
        int emps[3] = '{3, 3, 2};
        ready_mode = 0; fe_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fifo_q.delete(); exp_q.delete();
            preload((lens[k] + 3) / 4);
            make_exp(lens[k], 0);
            run_frame(lens[k], 600);
            checks++;
            if (beats_bad() != 0 || done_cnt != 1) begin
                failures++;
                $display("FAIL short_beats len=%0d got %0d beats (%0d bad) done=%0d required %0d matching, done=1",
                         lens[k], got_q.size(), beats_bad(), done_cnt, exp_q.size());
            end
            checks++;
            if (got_q.size() == 0 || got_q[got_q.size() - 1].emp !== 2'(emps[k]) || got_q[got_q.size() - 1].e !== 1'b1) begin
                failures++;
                $display("FAIL short_empty len=%0d got last-beat empty/eop mismatch (beats=%0d) required empty=%0d eop=1",
                         lens[k], got_q.size(), emps[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1; fe_en = 1'b0;
        fifo_q.delete(); exp_q.delete();
        preload(16);
        make_exp(64, 0);
        run_frame(64, 200);
        checks++;
        if (beats_bad() != 0 || got_q.size() != 16) begin
            failures++;
            $display("FAIL bp_beats got %0d beats (%0d bad) required 16 matching", got_q.size(), beats_bad());
        end
        checks++;
        if (hold_viol != 0 || stall_rdreq != 0) begin
            failures++;
            $display("FAIL bp_hold got hold_violations=%0d stall_rdreq=%0d required 0 and 0", hold_viol, stall_rdreq);
        end
        checks++;
        if (rdreq_cnt != 16 || done_cnt != 1) begin
            failures++;
            $display("FAIL bp_counts got rdreq=%0d done=%0d required 16 and 1", rdreq_cnt, done_cnt);
        end
    endtask

    task automatic test_underrun();
        int ab, nv;
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete(); exp_q.delete();
        preload(5);
        for (int i = 0; i < 5; i++) exp_q.push_back({fifo_q[i], (i == 0), 1'b0, 2'd0, 6'd0});
        exp_q.push_back({32'd0, 1'b0, 1'b1, 2'd0, 6'd1});
        run_frame(64, 100);
        ab = 2 + 5 + ULIM;
        nv = 0;
        for (int i = 7; i < ab; i++) if (tr_valid[i]) nv++;
        checks++;
        if (beats_bad() != 0) begin
            failures++;
            $display("FAIL underrun_beats got %0d beats (%0d bad) required 5 data + abort", got_q.size(), beats_bad());
        end
        checks++;
        if (nv != 0 || !tr_valid[6] || !tr_valid[ab] || !tr_eop[ab]) begin
            failures++;
            $display("FAIL underrun_gap got valid-in-gap=%0d v6=%b v%0d=%b eop=%b required 0,1,1,1",
                     nv, tr_valid[6], ab, tr_valid[ab], tr_eop[ab]);
        end
        checks++;
        if (done_cyc != ab + 1 || done_cnt != 1 || rdreq_cnt != 5) begin
            failures++;
            $display("FAIL underrun_done got done_cyc=%0d done=%0d rdreq=%0d required %0d,1,5",
                     done_cyc, done_cnt, rdreq_cnt, ab + 1);
        end
    endtask

    task automatic test_bad_len();
        int lens[2] = '{0, 1519};
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete();
        preload(4);
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            frame_len = 11'(lens[k]);
            pend_start = 1'b1;
            repeat (5) step();
            checks++;
            if (ferr_cnt != 1 || ferr_cyc != 1 || busy_cnt != 0 || rdreq_cnt != 0) begin
                failures++;
                $display("FAIL bad_len len=%0d got ferr=%0d@%0d busy_cycles=%0d rdreq=%0d required 1@1,0,0",
                         lens[k], ferr_cnt, ferr_cyc, busy_cnt, rdreq_cnt);
            end
        end
        checks++;
        if (fifo_q.size() != 4) begin
            failures++;
            $display("FAIL bad_len_fifo got %0d words left required 4", fifo_q.size());
        end
    endtask

    task automatic test_start_ignored();
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete(); exp_q.delete();
        preload(20);
        make_exp(64, 0);
        clear_logs();
        frame_len = 11'd64;
        pend_start = 1'b1;
        step();
        while (done_cnt == 0 && cyc < 100) begin
            if (cyc == 5) begin
                pend_start = 1'b1;
                frame_len = 11'd7;
            end
            step();
        end
        checks++;
        if (beats_bad() != 0 || rdreq_cnt != 16 || fifo_q.size() != 4) begin
            failures++;
            $display("FAIL start_ignored got beats=%0d bad=%0d rdreq=%0d fifo_left=%0d required 16,0,16,4",
                     got_q.size(), beats_bad(), rdreq_cnt, fifo_q.size());
        end
        frame_len = 11'd0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("FAIL start_ignored_idle got busy=%b done=%0d required 0 and 1", busy, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int e1, s2;
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete(); exp_q.delete();
        preload(16);
        make_exp(32, 0);
        make_exp(29, 8);
        clear_logs();
        b2b_arm = 1'b1;
        b2b_len = 11'd29;
        frame_len = 11'd32;
        pend_start = 1'b1;
        step();
        while (done_cnt < 2 && cyc < 200) step();
        e1 = -1; s2 = -1;
        for (int i = 0; i < TR; i++) begin
            if (e1 < 0 && tr_valid[i] && tr_eop[i]) e1 = i;
            else if (e1 >= 0 && s2 < 0 && tr_valid[i] && tr_sop[i]) s2 = i;
        end
        checks++;
        if (beats_bad() != 0 || done_cnt != 2) begin
            failures++;
            $display("FAIL b2b_beats got %0d beats (%0d bad) done=%0d required 16 matching, done=2",
                     got_q.size(), beats_bad(), done_cnt);
        end
        checks++;
        if (e1 < 0 || s2 - e1 != 3) begin
            failures++;
            $display("FAIL b2b_gap got eop@%0d sop@%0d required sop 3 cycles after eop", e1, s2);
        end
    endtask

    task automatic test_random();
        int len, w, extra;
        ready_mode = 2; fe_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 9))
                0:       len = 1;
                1:       len = MAXB;
                2:       len = $urandom_range(2, 8);
                default: len = $urandom_range(1, 200);
            endcase
            w = (len + 3) / 4;
            extra = $urandom_range(0, 3);
            fifo_q.delete(); exp_q.delete();
            preload(w + extra);
            make_exp(len, 0);
            run_frame(len, 4000);
            checks++;
            if (beats_bad() != 0 || done_cnt != 1) begin
                failures++;
                $display("FAIL rand_beats n=%0d len=%0d got %0d beats (%0d bad) done=%0d required %0d matching, done=1",
                         n, len, got_q.size(), beats_bad(), done_cnt, w);
            end
            checks++;
            if (rdreq_cnt != w || fifo_q.size() != extra) begin
                failures++;
                $display("FAIL rand_pops n=%0d len=%0d got rdreq=%0d left=%0d required %0d and %0d",
                         n, len, rdreq_cnt, fifo_q.size(), w, extra);
            end
            checks++;
            if (hold_viol != 0 || stall_rdreq != 0) begin
                failures++;
                $display("FAIL rand_hold n=%0d got hold_violations=%0d stall_rdreq=%0d required 0 and 0",
                         n, hold_viol, stall_rdreq);
            end
        end
        fe_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_mode = 0; fe_en = 1'b0;
        fifo_q.delete();
        preload(16);
        clear_logs();
        frame_len = 11'd64;
        pend_start = 1'b1;
        repeat (8) step();
        checks++;
        if (valid !== 1'b1 || sop !== 1'b0 || eop !== 1'b0) begin
            failures++;
            $display("FAIL mid_beat7 got valid=%b sop=%b eop=%b required 1,0,0", valid, sop, eop);
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({data_out, sop, eop, valid, empty, error, busy, done, frame_err, rdreq} !== 47'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got data=%h sop=%b eop=%b valid=%b empty=%0d error=%0d busy=%b done=%b ferr=%b rdreq=%b required all 0",
                     data_out, sop, eop, valid, empty, error, busy, done, frame_err, rdreq);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        test_frame_64("after_reset");
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; frame_len = 11'd0; rdempty = 1'b1; fifo_data = 32'd0; ready = 1'b0;
        ready_mode = 0; fe_en = 1'b0; pend_start = 1'b0; b2b_arm = 1'b0; b2b_len = 11'd0;
        clear_logs();
        test_reset();
        test_frame_64("frame64");
        test_short_frames();
        test_backpressure();
        test_underrun();
        test_bad_len();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_stream_tx.md
# packet_stream_tx

Transmit-side counterpart of the Ethernet sniffer's receive path. The block pulls 32-bit frame words from a show-ahead FIFO and drives them onto the same Avalon-ST-style stream the sniffer consumes: data, sop, eop, valid, empty and error, with ready backpressure. It generates loopback and bench traffic and is the egress path for frames re-emitted after inspection. One frame is sent per start command.

## Interface
Parameters:
- MAX_BYTES, 1518: largest legal frame length in bytes.
- UNDERRUN_LIMIT, 16: number of consecutive starved cycles before a frame is aborted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request. Sampled only in IDLE.
- frame_len  in  11  frame length in bytes. Sampled with start.
- rdempty  in  1  FIFO empty flag.
- fifo_data  in  32  FIFO head word. Valid when rdempty=0.
- rdreq  out  1  FIFO pop. Combinational.
- ready  in  1  sink ready. Ready latency is 0.
- data_out  out  32  stream data. Byte 0 is in [31:24].
- sop, eop, valid  out  1 each  stream framing.
- empty  out  2  count of unused bytes in the eop word. It is 0 on all other words.
- error  out  6  error bits. Bit 0 = underrun abort. Bits 5:1 are always 0.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the eop handshake.
- frame_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- Reset: state IDLE. All outputs 0, all counters 0.
- Transfer rule: a beat is transferred when valid & ready at the clock edge.
- Output register hold rule: while valid=1 and ready=0, data_out, sop, eop, empty and error hold their values.
- IDLE, on start:
  - If 1 ≤ frame_len ≤ MAX_BYTES: latch the length and set words_left = ceil(frame_len/4) (9 bits). Go to SEND.
  - Otherwise: pulse frame_err the next cycle and stay in IDLE.
  - start is ignored while busy.
- SEND:
  - rdreq = (words_left ≠ 0) & !rdempty & (!valid | ready).
  - On each rdreq, load fifo_data into the output register, set valid=1 and decrement words_left.
  - The first loaded word carries sop=1.
  - The word loaded when words_left = 1 carries eop=1 and empty = (4 − frame_len mod 4) mod 4.
  - If a beat is accepted and no new word is loaded, valid drops to 0.
  - When the eop beat is accepted, pulse done the next cycle and return to IDLE.
- Underrun:
  - The starve counter increments on each cycle in SEND with valid=0, words_left ≠ 0 and rdempty=1.
  - It clears whenever a word is loaded.
  - When it reaches UNDERRUN_LIMIT, go to ABORT.
- ABORT:
  - Present one beat: valid=1, eop=1, error=6'b000001, data_out=0, empty=0.
  - sop=1 only if no word of this frame has been sent yet.
  - Issue no rdreq. Leftover frame words stay in the FIFO; clearing them is the upstream's job.
  - When the abort beat is accepted, pulse done and return to IDLE.
- A reset asserted mid-frame forces IDLE immediately with all outputs 0. No eop is emitted.

## Timing
- Cycle 0: start is high.
- Cycle 1: state SEND; rdreq is high if the FIFO is non-empty.
- Cycle 2: first beat, valid=1 and sop=1.
- Throughput is 1 word per cycle with ready=1 and a non-empty FIFO.
- done and busy=0 appear in the cycle after the eop handshake.
- A new start is accepted in that same cycle. The minimum gap between eop and the next sop is 2 cycles.
- A 1-word frame carries sop=1 and eop=1 in the same beat.

## Test plan
- 64-byte frame, FIFO preloaded with 16 words, ready=1: valid in cycles 2–17, sop in cycle 2, eop in cycle 17 with empty=0, done in cycle 18, 16 rdreq pulses in total.
- 61-byte frame: 16 beats; eop beat has empty=3. 1-byte frame: a single beat with sop=eop=1 and empty=3.
- 64-byte frame with ready toggling 1,0,0,1 repeating: data held stable while ready=0, no word lost or duplicated, rdreq=0 during stalls, exactly 16 beats transferred.
- FIFO runs dry after 5 words, UNDERRUN_LIMIT=16: valid=0 for 16 cycles, then an abort beat with eop=1, error=1 and sop=0, then done.
- start with frame_len=0 and again with frame_len=1519: frame_err pulses, busy stays 0, no rdreq. start pulsed during a frame: ignored.
- n_rst asserted in the middle of beat 7: all outputs 0 asynchronously; after release, a new 64-byte frame transmits correctly.
